// File: rtl/wb_regfile_if.sv
// Write-back and operand-read bundle between the pipeline and the register file.
// The master drives the write triplet and read requests; the slave returns operands.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/wb_regfile.sv
// 2^ADDR_W x DATA_W register file, r0 hard-wired to zero, two combinational read
// ports with same-cycle write-to-read bypass. Registers clear asynchronously.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);
  localparam int NREG = 1 << ADDR_W;

  // Flattened view of every register, slot 0 constant zero, for the read muxes.
  logic [NREG*DATA_W-1:0] file_flat;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign file_flat[0 +: DATA_W] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] q_reg;
        logic              wr_hit;

        assign wr_hit = bus.we && (bus.waddr == ADDR_W'(gi));

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            q_reg <= '0;
          end else if (wr_hit) begin
            q_reg <= bus.wdata;
          end
        end

        assign file_flat[gi*DATA_W +: DATA_W] = q_reg;
      end
    end
  endgenerate

  logic              re_vec    [2];
  logic [ADDR_W-1:0] raddr_vec [2];
  logic [DATA_W-1:0] rdata_vec [2];

  assign re_vec[0]    = bus.re1;
  assign re_vec[1]    = bus.re2;
  assign raddr_vec[0] = bus.raddr1;
  assign raddr_vec[1] = bus.raddr2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rport
      // Address 0 wins over the bypass, so a discarded write to r0 never leaks out.
      always_comb begin
        rdata_vec[gi] = '0;
        if (rst && re_vec[gi] && (raddr_vec[gi] != '0)) begin
          if (bus.we && (bus.waddr == raddr_vec[gi])) begin
            rdata_vec[gi] = bus.wdata;
          end else begin
            rdata_vec[gi] = file_flat[raddr_vec[gi]*DATA_W +: DATA_W];
          end
        end
      end
    end
  endgenerate

  assign bus.rdata1 = rdata_vec[0];
  assign bus.rdata2 = rdata_vec[1];
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, hand-written reset sequence,
// and a randomized run against an array-based reference model.
module tb_wb_regfile;
  logic clk;
  logic rst;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total;
  int bad;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [13];
  logic [31:0] model [32];

  function automatic vec_t mk(logic r, logic w, logic [4:0] wa, logic [31:0] wd,
                              logic r1, logic [4:0] a1, logic r2, logic [4:0] a2,
                              logic [31:0] e1, logic [31:0] e2);
    vec_t v;
    v.rst = r; v.we = w; v.waddr = wa; v.wdata = wd;
    v.re1 = r1; v.raddr1 = a1; v.re2 = r2; v.raddr2 = a2;
    v.exp1 = e1; v.exp2 = e2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2);
    bus.we = w; bus.waddr = wa; bus.wdata = wd;
    bus.re1 = r1; bus.raddr1 = a1; bus.re2 = r2; bus.raddr2 = a2;
  endtask

  // Reference read: the priority rules applied to the model array.
  function automatic logic [31:0] ref_read(logic r, logic re, logic [4:0] ra,
                                           logic w, logic [4:0] wa, logic [31:0] wd);
    if (!r || !re || ra == 5'd0) return 32'h0;
    if (w && wa == ra) return wd;
    return model[ra];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] sub_res;
    logic [31:0] a;
    logic [31:0] b;
    logic        w, r1, r2;
    logic [4:0]  wa, a1, a2;
    logic [31:0] wd;

    total = 0;
    bad   = 0;
    a = 32'd5;
    b = 32'd7;
    sub_res = a - b;

    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd2);
    @(negedge clk);
    #1;
    check("reset_rd1", bus.rdata1, 32'h0);
    check("reset_rd2", bus.rdata2, 32'h0);

    vecs[0]  = mk(1, 1, 7,  32'h12345678, 1, 7,  0, 7,  32'h12345678, 32'h0);
    vecs[1]  = mk(1, 0, 0,  32'h0,        1, 7,  0, 7,  32'h12345678, 32'h0);
    vecs[2]  = mk(1, 1, 3,  32'h11111111, 0, 3,  0, 3,  32'h0,        32'h0);
    vecs[3]  = mk(1, 1, 3,  32'h22222222, 1, 3,  1, 3,  32'h22222222, 32'h22222222);
    vecs[4]  = mk(1, 0, 3,  32'h0,        1, 3,  1, 3,  32'h22222222, 32'h22222222);
    vecs[5]  = mk(1, 1, 0,  32'hFFFFFFFF, 1, 0,  1, 7,  32'h0,        32'h12345678);
    vecs[6]  = mk(1, 0, 0,  32'h0,        1, 0,  1, 3,  32'h0,        32'h22222222);
    vecs[7]  = mk(1, 1, 31, sub_res,      1, 31, 0, 31, 32'hFFFFFFFE, 32'h0);
    vecs[8]  = mk(1, 0, 0,  32'h0,        1, 31, 1, 31, 32'hFFFFFFFE, 32'hFFFFFFFE);
    vecs[9]  = mk(1, 1, 10, 32'hAAAA0001, 1, 10, 1, 10, 32'hAAAA0001, 32'hAAAA0001);
    vecs[10] = mk(1, 1, 10, 32'hAAAA0002, 1, 10, 1, 3,  32'hAAAA0002, 32'h22222222);
    vecs[11] = mk(1, 0, 10, 32'h0,        1, 10, 1, 10, 32'hAAAA0002, 32'hAAAA0002);
    vecs[12] = mk(1, 1, 5,  32'hDEADBEEF, 1, 5,  1, 3,  32'hDEADBEEF, 32'h22222222);

    // Table phase: inputs at negedge, combinational check, then the rising edge commits.
    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata,
            vecs[i].re1, vecs[i].raddr1, vecs[i].re2, vecs[i].raddr2);
      #1;
      $display("vec %0d: we=%0b wa=%0d wd=%h ra1=%0d rd1=%h ra2=%0d rd2=%h",
               i, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
               vecs[i].raddr1, bus.rdata1, vecs[i].raddr2, bus.rdata2);
      check($sformatf("vec%0d_rd1", i), bus.rdata1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), bus.rdata2, vecs[i].exp2);
      @(negedge clk);
    end

    // Mid-cycle reset clears r5 immediately; a write on the reset edge is dropped.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd31);
    #1;
    check("pre_reset_r5", bus.rdata1, 32'hDEADBEEF);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_rd1", bus.rdata1, 32'h0);
    check("midreset_rd2", bus.rdata2, 32'h0);
    drive(1'b1, 5'd6, 32'h55555555, 1'b1, 5'd6, 1'b1, 5'd5);
    #1;
    check("reset_bypass_blocked", bus.rdata1, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd6);
    #1;
    $display("post reset: r5=%h r6=%h", bus.rdata1, bus.rdata2);
    check("post_reset_r5", bus.rdata1, 32'h0);
    check("post_reset_r6", bus.rdata2, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b1, 5'd10);
    #1;
    check("post_reset_r31", bus.rdata1, 32'h0);
    check("post_reset_r10", bus.rdata2, 32'h0);
    @(negedge clk);

    // Random regression against the model.
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 63) != 0);
      w   = $urandom_range(0, 1) == 1;
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      r1  = $urandom_range(0, 3) != 0;
      r2  = $urandom_range(0, 3) != 0;
      a1  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(w, wa, wd, r1, a1, r2, a2);
      if (!rst) begin
        for (int k = 0; k < 32; k++) model[k] = 32'h0;
      end
      #1;
      check($sformatf("rand%0d_rd1", c), bus.rdata1, ref_read(rst, r1, a1, w, wa, wd));
      check($sformatf("rand%0d_rd2", c), bus.rdata2, ref_read(rst, r2, a2, w, wa, wd));
      @(posedge clk);
      if (rst && w && wa != 5'd0) model[wa] = wd;
      @(negedge clk);
    end
    $display("random phase: %0d cycles", 10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

General-purpose register file that consumes the write-back triplet (destination address, write enable, write data) produced by the execute stage. It provides the two operand read ports that the decode stage uses to source the execute stage's two operands. It holds 32 × 32-bit registers, with register 0 hard-wired to zero. A same-cycle write-to-read bypass lets an instruction reading a register see a result being written in that cycle without an extra stall.

## Interface
- DATA_W, 32, register and data width (matches the 32-bit register bus).
- ADDR_W, 5, register address width; the file holds 2^ADDR_W = 32 entries.
- clk  in  1  single clock; all register updates occur on its rising edge.
- rst  in  1  asynchronous, active-low reset; clears every register while low.
- we  in  1  write enable (the execute stage's write-register flag after pipelining).
- waddr  in  ADDR_W  destination register address.
- wdata  in  DATA_W  write data (the execute stage's result).
- re1  in  1  read enable, port 1.
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1 (reg1 operand).
- re2  in  1  read enable, port 2.
- raddr2  in  ADDR_W  read address, port 2.
- rdata2  out  DATA_W  read data, port 2 (reg2 operand).

## Operation
- Storage is 32 registers of DATA_W bits each.
- **Write:**
  - On a rising clk edge with rst high, we=1 and waddr≠0, register[waddr] ← wdata.
  - If we=0 or waddr=0, no register changes.
  - Register 0 is never stored and always reads as 0.
- **Read** (combinational; ports are independent and identical), with the rules checked in this priority order:
  1. rst low → rdata = 0.
  2. re = 0 → rdata = 0.
  3. raddr = 0 → rdata = 0.
  4. we = 1 and waddr = raddr → rdata = wdata (bypass of the value being written this cycle).
  5. Otherwise → rdata = register[raddr].
- **Bypass rules:**
  - Bypass applies to both ports simultaneously when both addresses match waddr.
  - Bypass never applies to address 0, even when we=1 and waddr=0.
- **Arithmetic/width:**
  - There is no arithmetic; data passes through at full DATA_W width with no sign or zero extension.
  - Addresses use all ADDR_W bits, so no out-of-range address exists.

## Timing
- **Reset:**
  - Asserting rst low clears all 32 registers immediately, without waiting for a clock edge.
  - rdata1 and rdata2 read 0 while rst is low.
  - A write presented on the same edge that rst is low is discarded.
- **Reset deassertion:** after rst goes high, the first rising edge may perform a write.
- **Write latency:** one cycle. A value written at edge N is returned from storage from edge N onward, and through the bypass in the cycle before edge N.
- **Read latency:** zero cycles (combinational from raddr, re, we, waddr and wdata).
- **Back-to-back writes:** consecutive writes to the same address — the last write wins at each edge.
- **Mid-operation reset:** rst falling between edges clears state asynchronously. No write completes until rst is high at a rising edge.

## Test plan
- **Reset clear:** write 0xDEADBEEF to r5, pull rst low mid-cycle → rdata1 with raddr1=5 and re1=1 reads 0 immediately; after release, r5 still reads 0.
- **Basic write/read:**
  - Write 0x12345678 to r7 at edge N.
  - At N+1, with re1=1, raddr1=7 and we=0, rdata1 = 0x12345678.
  - With re2=0, rdata2 = 0.
- **Bypass:**
  - r3 holds 0x11111111. In one cycle drive we=1, waddr=3, wdata=0x22222222, raddr1=raddr2=3 with re1=re2=1 → both rdata = 0x22222222 before the edge.
  - After the edge, with we=0, both rdata still read 0x22222222.
- **r0 immunity:** we=1, waddr=0, wdata=0xFFFFFFFF, raddr1=0, re1=1 → rdata1 = 0 both before and after the edge.
- **Subtraction result write-back:** drive the write port with the execute stage's subtraction result (5 − 7 = 0xFFFFFFFE, the expected wrapped 32-bit value) into r31 → a read of r31 returns 0xFFFFFFFE with no extension or truncation.
- **Random regression:** 10k cycles of random we, waddr, wdata, re and raddr against a reference model, including reset pulses → exact match on rdata1 and rdata2 every cycle.
